// File: rtl/dffram_byte_port_sched.sv
// Byte-wide access scheduler for a nibble-serial 32x8 2R1W DFF RAM.
// Port A is round-robin shared read/write between NREQ requesters; port B is a single read-only client.
module dffram_byte_port_sched #(
    parameter int NREQ  = 2,
    parameter int AW    = 5,
    parameter int DEPTH = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    a_valid,
    output logic [NREQ-1:0]    a_ready,
    input  logic [NREQ-1:0]    a_we,
    input  logic [NREQ*AW-1:0] a_addr,
    input  logic [NREQ*8-1:0]  a_wdata,
    output logic [NREQ-1:0]    a_rvalid,
    output logic [7:0]         a_rdata,
    output logic               a_err,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [AW-1:0]      b_addr,
    output logic               b_rvalid,
    output logic [7:0]         b_rdata,
    output logic               b_err,
    output logic [AW-1:0]      mem_addr_a,
    output logic [3:0]         mem_wdata_a,
    output logic               mem_wlo_a,
    output logic               mem_rhi_a,
    output logic               mem_wen,
    input  logic [3:0]         mem_rdata_a,
    output logic [AW-1:0]      mem_addr_b,
    output logic               mem_rhi_b,
    input  logic [3:0]         mem_rdata_b
);
    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    logic [AW-1:0] req_addr  [NREQ];
    logic [7:0]    req_wdata [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_addr[gi]  = a_addr[gi*AW +: AW];
        assign req_wdata[gi] = a_wdata[gi*8 +: 8];
    end

    // ---------------- port A arbitration ----------------
    state_t        a_state_reg;
    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand_idx;
    logic          grant_any;
    logic          a_accept;
    logic          a_sel_rng;

    // Scan downward so the candidate closest to the pointer wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_idx = PW'((int'(ptr_reg) + k) % NREQ);
            if (a_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign a_accept  = rst_n && (a_state_reg == IDLE) && grant_any;
    assign a_sel_rng = {1'b0, req_addr[grant_idx]} < DEPTH_W;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign a_ready[gi] = a_accept && (grant_idx == PW'(gi));
    end

    // ---------------- port A sequencing ----------------
    logic            a_we_reg;
    logic            a_rng_reg;
    logic [3:0]      a_wdata_hi_reg;
    logic [3:0]      a_rbuf_lo_reg;
    logic [NREQ-1:0] a_gnt_reg;
    logic            mem_wen_reg;

    // Reset gates the write strobe combinationally so an access aborted mid-byte never writes again.
    assign mem_wen = mem_wen_reg && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_state_reg    <= IDLE;
            ptr_reg        <= '0;
            a_we_reg       <= 1'b0;
            a_rng_reg      <= 1'b0;
            a_wdata_hi_reg <= '0;
            a_rbuf_lo_reg  <= '0;
            a_gnt_reg      <= '0;
            a_rvalid       <= '0;
            a_rdata        <= '0;
            a_err          <= 1'b0;
            mem_addr_a     <= '0;
            mem_wdata_a    <= '0;
            mem_wlo_a      <= 1'b0;
            mem_rhi_a      <= 1'b0;
            mem_wen_reg    <= 1'b0;
        end else begin
            a_rvalid <= '0;
            case (a_state_reg)
                IDLE: begin
                    if (a_accept) begin
                        a_we_reg       <= a_we[grant_idx];
                        a_rng_reg      <= a_sel_rng;
                        a_wdata_hi_reg <= req_wdata[grant_idx][7:4];
                        a_gnt_reg      <= a_ready;
                        ptr_reg        <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        mem_addr_a     <= req_addr[grant_idx];
                        mem_rhi_a      <= 1'b0;
                        mem_wlo_a      <= 1'b1;
                        mem_wdata_a    <= req_wdata[grant_idx][3:0];
                        mem_wen_reg    <= a_we[grant_idx] && a_sel_rng;
                        a_state_reg    <= LO;
                    end
                end
                LO: begin
                    a_rbuf_lo_reg <= mem_rdata_a;
                    mem_rhi_a     <= 1'b1;
                    mem_wlo_a     <= 1'b0;
                    mem_wdata_a   <= a_wdata_hi_reg;
                    a_state_reg   <= HI;
                end
                HI: begin
                    mem_wen_reg <= 1'b0;
                    a_rvalid    <= a_gnt_reg;
                    a_err       <= !a_rng_reg;
                    a_rdata     <= (a_we_reg || !a_rng_reg) ? 8'h00 : {mem_rdata_a, a_rbuf_lo_reg};
                    a_state_reg <= IDLE;
                end
                default: a_state_reg <= IDLE;
            endcase
        end
    end

    // ---------------- port B sequencing ----------------
    state_t     b_state_reg;
    logic       b_rng_reg;
    logic [3:0] b_rbuf_lo_reg;

    assign b_ready = rst_n && (b_state_reg == IDLE) && b_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_state_reg   <= IDLE;
            b_rng_reg     <= 1'b0;
            b_rbuf_lo_reg <= '0;
            b_rvalid      <= 1'b0;
            b_rdata       <= '0;
            b_err         <= 1'b0;
            mem_addr_b    <= '0;
            mem_rhi_b     <= 1'b0;
        end else begin
            b_rvalid <= 1'b0;
            case (b_state_reg)
                IDLE: begin
                    if (b_ready) begin
                        b_rng_reg   <= {1'b0, b_addr} < DEPTH_W;
                        mem_addr_b  <= b_addr;
                        mem_rhi_b   <= 1'b0;
                        b_state_reg <= LO;
                    end
                end
                LO: begin
                    b_rbuf_lo_reg <= mem_rdata_b;
                    mem_rhi_b     <= 1'b1;
                    b_state_reg   <= HI;
                end
                HI: begin
                    b_rvalid    <= 1'b1;
                    b_err       <= !b_rng_reg;
                    b_rdata     <= b_rng_reg ? {mem_rdata_b, b_rbuf_lo_reg} : 8'h00;
                    b_state_reg <= IDLE;
                end
                default: b_state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dffram_byte_port_sched.sv
// Bench for dffram_byte_port_sched: behavioural nibble RAM on the mem pins, a golden byte
// image for expected read data, and per-port response queues checked as responses appear.
module tb_dffram_byte_port_sched;
    localparam int NREQ = 2;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   a_valid, a_ready, a_we, a_rvalid;
    logic [NREQ*AW-1:0] a_addr;
    logic [NREQ*8-1:0] a_wdata;
    logic [7:0]        a_rdata, b_rdata;
    logic              a_err, b_valid, b_ready, b_rvalid, b_err;
    logic [AW-1:0]     b_addr, mem_addr_a, mem_addr_b;
    logic [3:0]        mem_wdata_a, mem_rdata_a, mem_rdata_b;
    logic              mem_wlo_a, mem_rhi_a, mem_wen, mem_rhi_b;

    dffram_byte_port_sched #(.NREQ(NREQ), .AW(AW), .DEPTH(26)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr_a(mem_addr_a), .mem_wdata_a(mem_wdata_a), .mem_wlo_a(mem_wlo_a),
        .mem_rhi_a(mem_rhi_a), .mem_wen(mem_wen), .mem_rdata_a(mem_rdata_a),
        .mem_addr_b(mem_addr_b), .mem_rhi_b(mem_rhi_b), .mem_rdata_b(mem_rdata_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(int i);
        return 8'((i * 29 + 7) % 256);
    endfunction

    // Pin-level RAM: reads are combinational, nibble writes land on the clock edge.
    logic [7:0] ram [32];
    logic       ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else if (mem_wen) begin
            if (mem_wlo_a) ram[mem_addr_a][3:0] <= mem_wdata_a;
            else           ram[mem_addr_a][7:4] <= mem_wdata_a;
        end
    end
    assign mem_rdata_a = mem_rhi_a ? ram[mem_addr_a][7:4] : ram[mem_addr_a][3:0];
    assign mem_rdata_b = mem_rhi_b ? ram[mem_addr_b][7:4] : ram[mem_addr_b][3:0];

    logic [7:0] gold [32];

    typedef struct {
        int         req;
        logic [7:0] rdata;
        logic       err;
        int         due;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t ea, eb;
    logic [NREQ-1:0] oh;

    int checks = 0;
    int passes = 0;

    // Response monitor: every rvalid pops the oldest expectation for that port.
    always @(negedge clk) begin
        if (a_rvalid != '0) begin
            checks++;
            if (a_q.size() == 0) begin
                $display("FAIL a_resp: got unexpected a_rvalid=%b, required no response", a_rvalid);
            end else begin
                ea = a_q.pop_front();
                oh = NREQ'(1 << ea.req);
                if (a_rvalid !== oh || a_rdata !== ea.rdata || a_err !== ea.err || cyc !== ea.due)
                    $display("FAIL a_resp: got rvalid=%b rdata=%h err=%b cyc=%0d, required rvalid=%b rdata=%h err=%b cyc=%0d",
                             a_rvalid, a_rdata, a_err, cyc, oh, ea.rdata, ea.err, ea.due);
                else
                    passes++;
            end
        end
        if (b_rvalid) begin
            checks++;
            if (b_q.size() == 0) begin
                $display("FAIL b_resp: got unexpected b_rvalid, required no response");
            end else begin
                eb = b_q.pop_front();
                if (b_rdata !== eb.rdata || b_err !== eb.err || cyc !== eb.due)
                    $display("FAIL b_resp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             b_rdata, b_err, cyc, eb.rdata, eb.err, eb.due);
                else
                    passes++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issue one port-A request; returns #1 after the accept edge (inside the LO cycle).
    task automatic a_req(input int r, input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rdata, input logic exp_err);
        bit got = 0;
        @(posedge clk); #1;
        a_we[r] = we;
        a_addr[r*AW +: AW] = addr;
        a_wdata[r*8 +: 8] = wdata;
        a_valid[r] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_ready[r]) begin
                got = 1;
                a_q.push_back('{req: r, rdata: exp_rdata, err: exp_err, due: cyc + 3});
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL a_accept_timeout: got no a_ready[%0d] in 20 cycles, required a grant", r);
        end
        @(posedge clk); #1;
        a_valid[r] = 1'b0;
        $display("A req%0d %s addr=%0d wdata=%h accepted=%0d", r, we ? "WR" : "RD", addr, wdata, got);
    endtask

    task automatic b_req(input logic [AW-1:0] addr, input logic [7:0] exp_rdata, input logic exp_err);
        bit got = 0;
        @(posedge clk); #1;
        b_addr = addr;
        b_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b_ready) begin
                got = 1;
                b_q.push_back('{req: 0, rdata: exp_rdata, err: exp_err, due: cyc + 3});
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL b_accept_timeout: got no b_ready in 20 cycles, required a grant");
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        $display("B RD addr=%0d accepted=%0d", addr, got);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_q.size() == 0 && b_q.size() == 0) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = '1;
        b_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_ready !== '0 || b_ready !== 1'b0 || mem_wen !== 1'b0)
            $display("FAIL reset_ready: got a_ready=%b b_ready=%b mem_wen=%b, required 0", a_ready, b_ready, mem_wen);
        else passes++;
        checks++;
        if (a_rvalid !== '0 || b_rvalid !== 1'b0 || mem_addr_a !== '0 || mem_rhi_a !== 1'b0 ||
            mem_wlo_a !== 1'b0 || mem_addr_b !== '0 || mem_rhi_b !== 1'b0 || a_rdata !== 8'h00)
            $display("FAIL reset_outputs: got a_rvalid=%b b_rvalid=%b mem_addr_a=%0d mem_addr_b=%0d, required all 0",
                     a_rvalid, b_rvalid, mem_addr_a, mem_addr_b);
        else passes++;
        a_valid = '0;
        b_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_write_read();
        a_req(0, 1'b1, 5'd3, 8'hA5, 8'h00, 1'b0);
        @(negedge clk);
        checks++;
        if (mem_addr_a !== 5'd3 || mem_wdata_a !== 4'h5 || mem_wlo_a !== 1'b1 || mem_rhi_a !== 1'b0 || mem_wen !== 1'b1)
            $display("FAIL lo_cycle: got addr=%0d wdata=%h wlo=%b rhi=%b wen=%b, required 3 5 1 0 1",
                     mem_addr_a, mem_wdata_a, mem_wlo_a, mem_rhi_a, mem_wen);
        else passes++;
        @(negedge clk);
        checks++;
        if (mem_addr_a !== 5'd3 || mem_wdata_a !== 4'hA || mem_wlo_a !== 1'b0 || mem_rhi_a !== 1'b1 || mem_wen !== 1'b1)
            $display("FAIL hi_cycle: got addr=%0d wdata=%h wlo=%b rhi=%b wen=%b, required 3 a 0 1 1",
                     mem_addr_a, mem_wdata_a, mem_wlo_a, mem_rhi_a, mem_wen);
        else passes++;
        gold[3] = 8'hA5;
        a_req(0, 1'b0, 5'd3, 8'h00, gold[3], 1'b0);
        checks++;
        if (ram[3] !== 8'hA5) $display("FAIL ram_byte3: got %h, required a5", ram[3]);
        else passes++;
        a_req(1, 1'b0, 5'd12, 8'h00, gold[12], 1'b0);
        drain();
    endtask

    task automatic test_round_robin();
        int n = 0;
        int last = 0;
        logic [NREQ-1:0] exp_oh;
        do_reset();
        a_we = '0;
        a_addr[0 +: AW] = 5'd1;
        a_addr[AW +: AW] = 5'd2;
        a_valid = 2'b11;
        for (int i = 0; i < 30 && n < 4; i++) begin
            @(negedge clk);
            if (a_ready != '0) begin
                exp_oh = (n % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if (a_ready !== exp_oh || (n > 0 && cyc - last != 3))
                    $display("FAIL rr_grant%0d: got a_ready=%b gap=%0d, required a_ready=%b gap=3",
                             n, a_ready, cyc - last, exp_oh);
                else passes++;
                a_q.push_back('{req: (n % 2), rdata: gold[(n % 2) + 1], err: 1'b0, due: cyc + 3});
                $display("A grant %0d -> a_ready=%b at cycle %0d", n, a_ready, cyc);
                last = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        a_valid = '0;
        checks++;
        if (n != 4) $display("FAIL rr_count: got %0d grants, required 4", n);
        else passes++;
        drain();
    endtask

    task automatic test_out_of_range();
        bit saw_wen = 0;
        a_req(1, 1'b1, 5'd26, 8'hFF, 8'h00, 1'b1);
        repeat (3) begin
            @(negedge clk);
            if (mem_wen !== 1'b0) saw_wen = 1;
        end
        checks++;
        if (saw_wen) $display("FAIL oor_wen: got mem_wen=1, required 0 for addr 26");
        else passes++;
        a_req(1, 1'b0, 5'd31, 8'h00, 8'h00, 1'b1);
        a_req(0, 1'b0, 5'd25, 8'h00, gold[25], 1'b0);
        b_req(5'd30, 8'h00, 1'b1);
        b_req(5'd25, gold[25], 1'b0);
        drain();
    endtask

    task automatic test_concurrent();
        @(posedge clk); #1;
        a_we[0] = 1'b1;
        a_addr[0 +: AW] = 5'd7;
        a_wdata[0 +: 8] = 8'h3C;
        a_valid[0] = 1'b1;
        b_addr = 5'd7;
        b_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 2'b01 || b_ready !== 1'b1)
            $display("FAIL same_cycle_accept: got a_ready=%b b_ready=%b, required 01 1", a_ready, b_ready);
        else passes++;
        a_q.push_back('{req: 0, rdata: 8'h00, err: 1'b0, due: cyc + 3});
        // No forwarding: both B nibble reads happen before the matching A write edges.
        b_q.push_back('{req: 0, rdata: gold[7], err: 1'b0, due: cyc + 3});
        @(posedge clk); #1;
        a_valid[0] = 1'b0;
        b_valid = 1'b0;
        $display("A WR addr=7 3c with same-cycle B RD addr=7, expect old %h", gold[7]);
        gold[7] = 8'h3C;
        drain();
        @(posedge clk); #1;
        a_we[0] = 1'b1;
        a_addr[0 +: AW] = 5'd8;
        a_wdata[0 +: 8] = 8'h5E;
        a_valid[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 2'b01) $display("FAIL offset_a_accept: got a_ready=%b, required 01", a_ready);
        else passes++;
        a_q.push_back('{req: 0, rdata: 8'h00, err: 1'b0, due: cyc + 3});
        @(posedge clk); #1;
        a_valid[0] = 1'b0;
        b_addr = 5'd8;
        b_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) $display("FAIL offset_b_accept: got b_ready=%b, required 1", b_ready);
        else passes++;
        // B lags by one cycle, so each of its nibble reads follows the matching A write edge.
        b_q.push_back('{req: 0, rdata: 8'h5E, err: 1'b0, due: cyc + 3});
        @(posedge clk); #1;
        b_valid = 1'b0;
        $display("A WR addr=8 5e with B RD addr=8 one cycle later, expect 5e");
        gold[8] = 8'h5E;
        drain();
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        logic [7:0] expect_byte;
        expect_byte = {gold[10][7:4], 4'h6};
        a_req(0, 1'b1, 5'd10, 8'h96, 8'h00, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        a_q.delete();
        @(negedge clk);
        checks++;
        if (mem_wen !== 1'b0) $display("FAIL reset_hi_wen: got mem_wen=%b during reset, required 0", mem_wen);
        else passes++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_wen !== 1'b0 || a_rvalid !== '0) bad = 1;
        end
        checks++;
        if (bad) $display("FAIL reset_abort: got mem_wen or a_rvalid after reset, required none");
        else passes++;
        checks++;
        if (ram[10] !== expect_byte) $display("FAIL partial_write: got ram[10]=%h, required %h", ram[10], expect_byte);
        else passes++;
        gold[10] = expect_byte;
        a_req(1, 1'b0, 5'd10, 8'h00, gold[10], 1'b0);
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = '0;
        a_we = '0;
        a_addr = '0;
        a_wdata = '0;
        b_valid = 1'b0;
        b_addr = '0;
        for (int i = 0; i < 32; i++) gold[i] = init_val(i);
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_concurrent();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++;
        if (a_q.size() != 0 || b_q.size() != 0)
            $display("FAIL leftover: got %0d A and %0d B responses outstanding, required 0", a_q.size(), b_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
